// File: rtl/spi_apb_sequencer.sv
// spi_apb_sequencer
//   APB master with a two-client round-robin arbiter in front of the
//   spi_top_block register file. A granted request programs CR1 and BR only
//   when they differ from the cached copies. It then writes the TX byte to DR,
//   waits for the transfer-complete interrupt and reads DR back. The received
//   byte is returned to the client with a one-cycle done pulse.
//
// Ports
//   pclk, preset        clock, synchronous active-high reset
//   req_i[1:0]          request levels, held until the matching done_o pulse
//   cr1_*_i, br_*_i     per-client CR1 / BR values
//   tx_*_i              per-client TX byte
//   done_o[1:0]         one-hot completion pulse to the served client
//   rx_data_o, err_o    result byte and error flag, valid with done_o
//   busy_o              high from grant through the done_o cycle
//   paddr_o .. pwdata_o APB master request signals (all registered)
//   prdata_i, pready_i, pslverr_i  APB slave response
//   spi_int_req_i       transfer-complete interrupt level
module spi_apb_sequencer #(
  parameter logic [2:0]  CR1_ADDR       = 3'd0,
  parameter logic [2:0]  BR_ADDR        = 3'd2,
  parameter logic [2:0]  DR_ADDR        = 3'd5,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic [1:0] req_i,
  input  logic [7:0] cr1_0_i,
  input  logic [7:0] cr1_1_i,
  input  logic [7:0] br_0_i,
  input  logic [7:0] br_1_i,
  input  logic [7:0] tx_0_i,
  input  logic [7:0] tx_1_i,
  output logic [1:0] done_o,
  output logic [7:0] rx_data_o,
  output logic       err_o,
  output logic       busy_o,
  output logic [2:0] paddr_o,
  output logic       pwrite_o,
  output logic       psel_o,
  output logic       penable_o,
  output logic [7:0] pwdata_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i,
  input  logic       pslverr_i,
  input  logic       spi_int_req_i
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_IRQ, DONE} state_t;
  typedef enum logic [1:0] {OP_CR1_W, OP_BR_W, OP_DR_W, OP_DR_R} op_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  op_t         op;
  op_t         nxt_op;
  logic        start_op;
  logic        rr_ptr;
  logic        gnt;
  logic        gnt_sel;
  logic [1:0]  done_onehot;
  logic [7:0]  cr1_q, br_q, tx_q;
  logic [7:0]  cr1_cache, br_cache;
  logic        cr1_vld, br_vld;
  logic [7:0]  cr1_src, br_src, tx_src;
  logic        cr1_miss, br_miss;
  logic [15:0] tmo_cnt;

  function automatic logic [2:0] op_addr(input op_t o);
    case (o)
      OP_CR1_W: op_addr = CR1_ADDR;
      OP_BR_W:  op_addr = BR_ADDR;
      default:  op_addr = DR_ADDR;
    endcase
  endfunction

  function automatic logic [7:0] op_wdata(input op_t o, input logic [7:0] c,
                                          input logic [7:0] b, input logic [7:0] t);
    case (o)
      OP_CR1_W: op_wdata = c;
      OP_BR_W:  op_wdata = b;
      OP_DR_W:  op_wdata = t;
      default:  op_wdata = 8'h00;
    endcase
  endfunction

  // rr_ptr names the favoured client; the other one wins only when the
  // favoured client is not requesting.
  assign gnt_sel     = req_i[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign done_onehot = gnt ? 2'b10 : 2'b01;

  // During IDLE the cache decision has to look at the live inputs of the
  // client about to be granted; afterwards the latched copies are used.
  always_comb begin
    if (state == IDLE) begin
      cr1_src = gnt_sel ? cr1_1_i : cr1_0_i;
      br_src  = gnt_sel ? br_1_i  : br_0_i;
      tx_src  = gnt_sel ? tx_1_i  : tx_0_i;
    end else begin
      cr1_src = cr1_q;
      br_src  = br_q;
      tx_src  = tx_q;
    end
  end

  assign cr1_miss = !cr1_vld || (cr1_src != cr1_cache);
  assign br_miss  = !br_vld  || (br_src  != br_cache);

  // Decides when a new APB op begins and which one it is.
  always_comb begin
    start_op = 1'b0;
    nxt_op   = OP_DR_W;
    case (state)
      IDLE: begin
        if (|req_i) begin
          start_op = 1'b1;
          if (cr1_miss)     nxt_op = OP_CR1_W;
          else if (br_miss) nxt_op = OP_BR_W;
          else              nxt_op = OP_DR_W;
        end
      end
      ACCESS: begin
        if (pready_i && !pslverr_i) begin
          if (op == OP_CR1_W) begin
            start_op = 1'b1;
            nxt_op   = br_miss ? OP_BR_W : OP_DR_W;
          end else if (op == OP_BR_W) begin
            start_op = 1'b1;
            nxt_op   = OP_DR_W;
          end
        end
      end
      WAIT_IRQ: begin
        if (spi_int_req_i) begin
          start_op = 1'b1;
          nxt_op   = OP_DR_R;
        end
      end
      default: ;
    endcase
  end

  // Request operands and cache contents; validity lives in the control block.
  always_ff @(posedge pclk) begin
    if (state == IDLE && |req_i) begin
      cr1_q <= cr1_src;
      br_q  <= br_src;
      tx_q  <= tx_src;
    end
    if (state == ACCESS && pready_i && !pslverr_i) begin
      if (op == OP_CR1_W) cr1_cache <= cr1_q;
      if (op == OP_BR_W)  br_cache  <= br_q;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      op        <= OP_CR1_W;
      rr_ptr    <= 1'b0;
      gnt       <= 1'b0;
      cr1_vld   <= 1'b0;
      br_vld    <= 1'b0;
      tmo_cnt   <= 16'd0;
      done_o    <= 2'b00;
      rx_data_o <= 8'h00;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      paddr_o   <= 3'd0;
      pwrite_o  <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwdata_o  <= 8'h00;
    end else begin
      done_o <= 2'b00;
      case (state)
        IDLE: ;
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            penable_o <= 1'b0;
            if (pslverr_i) begin
              psel_o    <= 1'b0;
              cr1_vld   <= 1'b0;
              br_vld    <= 1'b0;
              err_o     <= 1'b1;
              rx_data_o <= 8'h00;
              done_o    <= done_onehot;
              state     <= DONE;
            end else begin
              case (op)
                OP_CR1_W: cr1_vld <= 1'b1;
                OP_BR_W:  br_vld  <= 1'b1;
                OP_DR_W: begin
                  psel_o  <= 1'b0;
                  tmo_cnt <= 16'd0;
                  state   <= WAIT_IRQ;
                end
                default: begin
                  psel_o    <= 1'b0;
                  err_o     <= 1'b0;
                  rx_data_o <= prdata_i;
                  done_o    <= done_onehot;
                  state     <= DONE;
                end
              endcase
            end
          end
        end
        WAIT_IRQ: begin
          if (!spi_int_req_i) begin
            if (tmo_cnt == TMO_LAST) begin
              cr1_vld   <= 1'b0;
              br_vld    <= 1'b0;
              err_o     <= 1'b1;
              rx_data_o <= 8'h00;
              done_o    <= done_onehot;
              state     <= DONE;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
        end
        DONE: begin
          busy_o    <= 1'b0;
          err_o     <= 1'b0;
          rx_data_o <= 8'h00;
          rr_ptr    <= ~gnt;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new op always enters SETUP; ACCESS->SETUP keeps psel_o high.
      if (start_op) begin
        if (state == IDLE) begin
          gnt    <= gnt_sel;
          busy_o <= 1'b1;
        end
        op        <= nxt_op;
        state     <= SETUP;
        psel_o    <= 1'b1;
        penable_o <= 1'b0;
        paddr_o   <= op_addr(nxt_op);
        pwrite_o  <= (nxt_op != OP_DR_R);
        pwdata_o  <= op_wdata(nxt_op, cr1_src, br_src, tx_src);
      end
    end
  end

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Directed testbench for spi_apb_sequencer with a scoreboard of expected
// APB transfers and completions, and a behavioural APB slave / SPI model.
module tb_spi_apb_sequencer;

  localparam logic [2:0] CR1A = 3'd0;
  localparam logic [2:0] BRA  = 3'd2;
  localparam logic [2:0] DRA  = 3'd5;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic [1:0] req_i = 2'b00;
  logic [7:0] cr1_0_i = 8'h00, cr1_1_i = 8'h00;
  logic [7:0] br_0_i = 8'h00, br_1_i = 8'h00;
  logic [7:0] tx_0_i = 8'h00, tx_1_i = 8'h00;
  logic [1:0] done_o;
  logic [7:0] rx_data_o;
  logic       err_o, busy_o;
  logic [2:0] paddr_o;
  logic       pwrite_o, psel_o, penable_o;
  logic [7:0] pwdata_o;
  logic [7:0] prdata_i = 8'h00;
  logic       pready_i = 1'b0;
  logic       pslverr_i = 1'b0;
  logic       spi_int_req_i = 1'b0;

  always #5 pclk = ~pclk;

  spi_apb_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset), .req_i(req_i),
    .cr1_0_i(cr1_0_i), .cr1_1_i(cr1_1_i), .br_0_i(br_0_i), .br_1_i(br_1_i),
    .tx_0_i(tx_0_i), .tx_1_i(tx_1_i),
    .done_o(done_o), .rx_data_o(rx_data_o), .err_o(err_o), .busy_o(busy_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .spi_int_req_i(spi_int_req_i)
  );

  typedef struct packed {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
  } apb_t;

  typedef struct packed {
    logic [1:0]  done;
    logic [7:0]  rx;
    logic        err;
    logic [15:0] cyc;  // 0 = completion cycle not checked
  } done_t;

  apb_t  exp_apb[$];
  done_t exp_done[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave model configuration, written by the stimulus
  logic [7:0] rd_byte = 8'h00;
  int         irq_delay = 0;  // 0 = interrupt never raised
  int         wait_req = 0;
  logic [2:0] wait_addr = 3'd0;
  logic       err_en = 1'b0;
  logic [2:0] err_addr = 3'd0;
  int         irq_cnt = 0;
  int         wcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    cyc++;
  endtask

  task automatic push_w(input logic [2:0] a, input logic [7:0] d);
    apb_t t;
    t.w = 1'b1; t.a = a; t.d = d;
    exp_apb.push_back(t);
  endtask

  task automatic push_r();
    apb_t t;
    t.w = 1'b0; t.a = DRA; t.d = 8'h00;
    exp_apb.push_back(t);
  endtask

  task automatic push_done(input logic [1:0] d, input logic [7:0] rx,
                           input logic e, input logic [15:0] c);
    done_t t;
    t.done = d; t.rx = rx; t.err = e; t.cyc = c;
    exp_done.push_back(t);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
                done_o, rx_data_o, err_o, busy_o});
  endfunction

  // Waits (bounded) for a done_o pulse and compares it with the next
  // expected completion.
  task automatic wait_done(input string tag, input int budget);
    done_t e;
    int    n;
    bit    seen;
    n = 0;
    seen = 0;
    e = '0;
    if (exp_done.size() != 0) e = exp_done.pop_front();
    while (!seen && n < budget) begin
      tick();
      n++;
      if (done_o != 2'b00) seen = 1;
    end
    chk({tag, "_done"}, 32'(done_o), 32'(e.done));
    if (seen) begin
      chk({tag, "_rx"}, 32'(rx_data_o), 32'(e.rx));
      chk({tag, "_err"}, 32'(err_o), 32'(e.err));
      if (e.cyc != 16'd0) chk({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
    end
  endtask

  // APB slave and SPI interrupt model; also checks each completed transfer.
  always @(negedge pclk) begin : slave
    apb_t got;
    apb_t e;
    if (preset) begin
      pready_i      = 1'b0;
      pslverr_i     = 1'b0;
      spi_int_req_i = 1'b0;
      irq_cnt       = 0;
      wcnt          = 0;
    end else begin
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) spi_int_req_i = 1'b1;
      end
      if (psel_o && penable_o) begin
        if (pwrite_o && paddr_o == wait_addr && wcnt < wait_req) begin
          pready_i = 1'b0;
          wcnt++;
        end else begin
          pready_i  = 1'b1;
          wcnt      = 0;
          pslverr_i = err_en && pwrite_o && (paddr_o == err_addr);
          prdata_i  = (!pwrite_o && paddr_o == DRA) ? rd_byte : 8'h00;
          got.w = pwrite_o;
          got.a = paddr_o;
          got.d = pwrite_o ? pwdata_o : 8'h00;
          checks++;
          assert (exp_apb.size() != 0) else begin
            errors++;
            $error("FAIL apb_unexpected: observed w=%0d a=%0d d=%0h expected no transfer",
                   got.w, got.a, got.d);
          end
          if (exp_apb.size() != 0) begin
            e = exp_apb.pop_front();
            chk("apb_xfer", 32'(got), 32'(e));
          end
          if (pwrite_o && paddr_o == DRA && !pslverr_i && irq_delay > 0) irq_cnt = irq_delay;
          if (!pwrite_o && paddr_o == DRA) spi_int_req_i = 1'b0;
        end
      end else begin
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        wcnt      = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset
    preset = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 32'd0);
    preset = 1'b0;
    tick();

    // full transaction, cache cold: CR1, BR, DR write, DR read
    cr1_0_i = 8'h50; br_0_i = 8'h01; tx_0_i = 8'hA5;
    rd_byte = 8'h55; irq_delay = 12;
    push_w(CR1A, 8'h50); push_w(BRA, 8'h01); push_w(DRA, 8'hA5); push_r();
    push_done(2'b01, 8'h55, 1'b0, 16'd21);
    req_i = 2'b01; cyc = 0;
    tick();
    chk("t1_setup_cr1", 32'({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o}),
        32'({1'b1, 1'b0, 1'b1, CR1A, 8'h50}));
    chk("t1_busy", 32'(busy_o), 32'd1);
    tick();
    chk("t1_access_cr1", 32'({psel_o, penable_o}), 32'(2'b11));
    wait_done("t1", 200);
    req_i = 2'b00;
    chk("t1_busy_at_done", 32'(busy_o), 32'd1);
    tick();
    chk("t1_idle_after", 32'({busy_o, done_o}), 32'd0);

    // same request: cache hit, DR write first; interrupt on the last
    // timeout-counter cycle must still be accepted
    irq_delay = 16;
    push_w(DRA, 8'hA5); push_r();
    push_done(2'b01, 8'h55, 1'b0, 16'd21);
    req_i = 2'b01; cyc = 0;
    tick();
    chk("t2_setup_dr", 32'({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o}),
        32'({1'b1, 1'b0, 1'b1, DRA, 8'hA5}));
    wait_done("t2", 200);
    req_i = 2'b00;
    tick();

    // slave error on the BR write from client 1
    cr1_1_i = 8'h50; br_1_i = 8'h07; tx_1_i = 8'h99;
    err_en = 1'b1; err_addr = BRA; rd_byte = 8'hEE;
    push_w(BRA, 8'h07);
    push_done(2'b10, 8'h00, 1'b1, 16'd3);
    req_i = 2'b10; cyc = 0;
    wait_done("t3_slverr", 100);
    req_i = 2'b00; err_en = 1'b0;
    tick();

    // both clients held: grants 0, 1, 0; cache was invalidated by the error
    cr1_0_i = 8'h50; br_0_i = 8'h01; tx_0_i = 8'h11;
    cr1_1_i = 8'h51; br_1_i = 8'h01; tx_1_i = 8'h22;
    rd_byte = 8'h3C; irq_delay = 4;
    push_w(CR1A, 8'h50); push_w(BRA, 8'h01); push_w(DRA, 8'h11); push_r();
    push_w(CR1A, 8'h51); push_w(DRA, 8'h22); push_r();
    push_w(CR1A, 8'h50); push_w(DRA, 8'h11); push_r();
    push_done(2'b01, 8'h3C, 1'b0, 16'd0);
    push_done(2'b10, 8'h3C, 1'b0, 16'd0);
    push_done(2'b01, 8'h3C, 1'b0, 16'd0);
    req_i = 2'b11; cyc = 0;
    wait_done("t4_g0", 200);
    wait_done("t4_g1", 200);
    wait_done("t4_g2", 200);
    req_i = 2'b00;
    tick();

    // wait states on the CR1 write
    cr1_0_i = 8'h60; br_0_i = 8'h01; tx_0_i = 8'h77;
    wait_addr = CR1A; wait_req = 3; rd_byte = 8'h81;
    push_w(CR1A, 8'h60); push_w(DRA, 8'h77); push_r();
    push_done(2'b01, 8'h81, 1'b0, 16'd0);
    req_i = 2'b01; cyc = 0;
    tick();
    chk("t5_setup", 32'({psel_o, penable_o}), 32'(2'b10));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_access_hold", 32'({psel_o, penable_o, paddr_o, pwdata_o}),
          32'({1'b1, 1'b1, CR1A, 8'h60}));
    end
    tick();
    chk("t5_next_setup", 32'({psel_o, penable_o, paddr_o}), 32'({1'b1, 1'b0, DRA}));
    wait_done("t5", 200);
    req_i = 2'b00; wait_req = 0;
    tick();

    // reset while waiting for the interrupt (client 1, cache hit)
    cr1_1_i = 8'h60; br_1_i = 8'h01; tx_1_i = 8'h55;
    irq_delay = 0;
    push_w(DRA, 8'h55);
    req_i = 2'b10; cyc = 0;
    repeat (6) tick();
    preset = 1'b1; req_i = 2'b00;
    tick();
    chk("t6_reset_outputs", all_outs(), 32'd0);
    preset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_done", 32'(done_o), 32'd0);
    end

    // after reset: pointer favours client 0 and the cache is cold again
    cr1_0_i = 8'h60; br_0_i = 8'h01; tx_0_i = 8'h66;
    rd_byte = 8'h5A; irq_delay = 4;
    push_w(CR1A, 8'h60); push_w(BRA, 8'h01); push_w(DRA, 8'h66); push_r();
    push_done(2'b01, 8'h5A, 1'b0, 16'd0);
    req_i = 2'b11; cyc = 0;
    wait_done("t7", 200);
    req_i = 2'b00;
    tick();

    // interrupt never arrives: timeout 16 cycles after WAIT_IRQ entry
    cr1_1_i = 8'h60; br_1_i = 8'h01; tx_1_i = 8'h44;
    irq_delay = 0;
    push_w(DRA, 8'h44);
    push_done(2'b10, 8'h00, 1'b1, 16'd19);
    req_i = 2'b10; cyc = 0;
    wait_done("t8_timeout", 100);
    req_i = 2'b00;
    repeat (3) tick();

    chk("apb_queue_empty", 32'(exp_apb.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
